// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Lock-qualified reset generator for the 180 MHz PLL domain.
//               Synchronises the PLL locked flag, requires a programmable run
//               of continuous lock, then holds reset for a further number of
//               cycles before releasing it. Any loss of lock while running
//               re-asserts reset and is recorded in a saturating counter and
//               a sticky flag.
// Ports       : clock           - 180 MHz PLL output clock
//               reset_n         - asynchronous active-low reset
//               locked          - PLL lock flag (asynchronous to clock)
//               clear_status    - single-cycle pulse, clears loss status
//               sys_reset_n     - registered active-low domain reset
//               ready           - high only in RUN
//               lock_lost       - sticky lock-loss flag
//               lock_loss_count - saturating lock-loss count
//               state           - FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       clear_status,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state
);

  localparam int c_max_cycles = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

  localparam logic [1:0] c_wait_lock = 2'd0;
  localparam logic [1:0] c_stable    = 2'd1;
  localparam logic [1:0] c_hold      = 2'd2;
  localparam logic [1:0] c_run       = 2'd3;

  localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(RESET_HOLD_CYCLES - 1);

  logic               r_sync1;
  logic               r_lock_sync;
  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sys_reset_n;
  logic               r_ready;
  logic               r_lock_lost;
  logic [7:0]         r_loss_count;

  logic [1:0]         w_state_next;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic               w_loss;
  logic               w_sys_reset_n_next;
  logic               w_ready_next;
  logic               w_lock_lost_next;
  logic [7:0]         w_loss_count_next;

  // State, counter, synchroniser and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1       <= 1'b0;
      r_lock_sync   <= 1'b0;
      r_state       <= c_wait_lock;
      r_cnt         <= '0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_loss_count  <= 8'd0;
    end else begin
      r_sync1       <= locked;
      r_lock_sync   <= r_sync1;
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_sys_reset_n <= w_sys_reset_n_next;
      r_ready       <= w_ready_next;
      r_lock_lost   <= w_lock_lost_next;
      r_loss_count  <= w_loss_count_next;
    end
  end

  // Next-state and qualification counter. The counter is cleared on every
  // transition so it never needs to count past the larger terminal value.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_loss       = 1'b0;
    case (r_state)
      c_wait_lock: begin
        w_cnt_next = '0;
        if (r_lock_sync) begin
          w_state_next = c_stable;
        end
      end
      c_stable: begin
        if (!r_lock_sync) begin
          w_state_next = c_wait_lock;
          w_cnt_next   = '0;
        end else if (r_cnt == c_stable_last) begin
          w_state_next = c_hold;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      c_hold: begin
        if (!r_lock_sync) begin
          w_state_next = c_wait_lock;
          w_cnt_next   = '0;
        end else if (r_cnt == c_hold_last) begin
          w_state_next = c_run;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next = '0;
        if (!r_lock_sync) begin
          w_state_next = c_wait_lock;
          w_loss       = 1'b1;
        end
      end
    endcase
  end

  // Outputs are derived from the next state so they move on the same edge
  // as the state register. A loss coinciding with a clear counts from zero.
  always_comb begin
    w_sys_reset_n_next = (w_state_next == c_run);
    w_ready_next       = (w_state_next == c_run);
    w_lock_lost_next   = r_lock_lost;
    w_loss_count_next  = r_loss_count;
    if (w_loss) begin
      w_lock_lost_next = 1'b1;
      if (clear_status) begin
        w_loss_count_next = 8'd1;
      end else if (r_loss_count != 8'hFF) begin
        w_loss_count_next = r_loss_count + 8'd1;
      end
    end else if (clear_status) begin
      w_lock_lost_next  = 1'b0;
      w_loss_count_next = 8'd0;
    end
  end

  assign sys_reset_n     = r_sys_reset_n;
  assign ready           = r_ready;
  assign lock_lost       = r_lock_lost;
  assign lock_loss_count = r_loss_count;
  assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench for pll_reset_sequencer with
//               LOCK_STABLE_CYCLES=4 and RESET_HOLD_CYCLES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       clear_status;
  logic       sys_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_count;
  logic [1:0] state;

  int n_checks;
  int n_errors;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .RESET_HOLD_CYCLES (2)
  ) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .locked         (locked),
    .clear_status   (clear_status),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle to a sampling point 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    locked       = 1'b0;
    clear_status = 1'b0;
    repeat (5) tick();
    reset_n = 1'b1;
  endtask

  // Raise locked and walk the 9-edge qualification sequence against a
  // hand-written state table: edges 1-2 WAIT, 3-6 STABLE, 7-8 HOLD, 9 RUN.
  task automatic relock_and_check(input string tag);
    logic [1:0] exp_state [1:9];
    exp_state = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    locked = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check({tag, "_state"}, 32'(state), 32'(exp_state[e]));
      check({tag, "_srstn"}, 32'(sys_reset_n), (e == 9) ? 32'd1 : 32'd0);
      check({tag, "_ready"}, 32'(ready), (e == 9) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic quick_loss_cycle();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (9) tick();
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset_n      = 1'b0;
    locked       = 1'b0;
    clear_status = 1'b0;

    // 1. Power-up.
    repeat (5) tick();
    check("rst_srstn", 32'(sys_reset_n), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(lock_loss_count), 32'd0);
    check("rst_lost",  32'(lock_lost), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("pwr_outs", {29'd0, sys_reset_n, state}, 32'd0);
      check("pwr_ready", 32'(ready), 32'd0);
      check("pwr_count", 32'(lock_loss_count), 32'd0);
    end

    // 2. Clean lock.
    relock_and_check("clean");
    check("clean_count", 32'(lock_loss_count), 32'd0);

    // 3. Glitch during STABLE: high 4 edges, low 3 edges, then high.
    do_reset();
    locked = 1'b1;
    repeat (4) tick();
    check("glitch_in_stable", 32'(state), 32'd1);
    locked = 1'b0;
    repeat (3) tick();
    check("glitch_back_wait", 32'(state), 32'd0);
    check("glitch_srstn", 32'(sys_reset_n), 32'd0);
    relock_and_check("glitch");
    check("glitch_count", 32'(lock_loss_count), 32'd0);
    check("glitch_lost",  32'(lock_lost), 32'd0);

    // 4. Loss in RUN.
    locked = 1'b0;
    tick();
    check("loss_e1_srstn", 32'(sys_reset_n), 32'd1);
    tick();
    check("loss_e2_srstn", 32'(sys_reset_n), 32'd1);
    check("loss_e2_count", 32'(lock_loss_count), 32'd0);
    tick();
    check("loss_e3_srstn", 32'(sys_reset_n), 32'd0);
    check("loss_e3_ready", 32'(ready), 32'd0);
    check("loss_e3_state", 32'(state), 32'd0);
    check("loss_count", 32'(lock_loss_count), 32'd1);
    check("loss_lost",  32'(lock_lost), 32'd1);
    relock_and_check("relock");
    check("relock_lost",  32'(lock_lost), 32'd1);
    check("relock_count", 32'(lock_loss_count), 32'd1);

    // 5. Saturation: 255 more losses bring the total to 256.
    for (int i = 0; i < 255; i++) begin
      quick_loss_cycle();
      check("sat_run", 32'(state), 32'd3);
    end
    check("sat_count", 32'(lock_loss_count), 32'd255);
    check("sat_lost",  32'(lock_lost), 32'd1);

    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("clr_count", 32'(lock_loss_count), 32'd0);
    check("clr_lost",  32'(lock_lost), 32'd0);
    check("clr_state", 32'(state), 32'd3);

    // Clear on the same edge as the loss is registered.
    locked = 1'b0;
    repeat (2) tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("clrloss_srstn", 32'(sys_reset_n), 32'd0);
    check("clrloss_count", 32'(lock_loss_count), 32'd1);
    check("clrloss_lost",  32'(lock_lost), 32'd1);

    // 6. Async reset in RUN, mid-cycle.
    relock_and_check("pre_async");
    #3;
    reset_n = 1'b0;
    #1;
    check("async_srstn", 32'(sys_reset_n), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_count", 32'(lock_loss_count), 32'd0);
    check("async_lost",  32'(lock_lost), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
